// File: rtl/gray_timer_scheduler.sv
// gray_timer_scheduler: round-robin arbiter that lends one shared interval
// counter to NUM_REQ requesters, runs each granted interval to its captured
// terminal count, and exposes the running count in Gray code.
module gray_timer_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                         Clk_In,
  input  logic                         Resetb_In,
  input  logic [NUM_REQ-1:0]           Req_In,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] Duration_In,
  input  logic                         Pause_In,
  input  logic                         Abort_In,
  output logic [NUM_REQ-1:0]           Grant_Out,
  output logic [NUM_REQ-1:0]           Done_Out,
  output logic                         Busy_Out,
  output logic [CNT_WIDTH-1:0]         Gray_Count_Out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] dur_q, dur_d;
  logic [CNT_WIDTH-1:0] gray_q, gray_d;
  logic                 busy_q, busy_d;

  logic [CNT_WIDTH-1:0] dur_arr [NUM_REQ];
  logic [PTR_W-1:0]     sel_idx;
  logic [PTR_W-1:0]     sel_next;
  logic [PTR_W-1:0]     cand_idx;
  logic                 sel_found;
  logic                 req_any;
  logic                 owner_req;
  logic                 at_term;
  int                   cand;

  assign req_any   = |Req_In;
  assign owner_req = |(Req_In & grant_q);
  assign at_term   = (cnt_q == dur_q);

  // Split the flat duration bus into one terminal count per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dur_arr[i] = Duration_In[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // Pick the first pending requester at or after the round-robin pointer
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(ptr_q) + i) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!sel_found && Req_In[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
    sel_next = (int'(sel_idx) + 1 == NUM_REQ) ? '0 : sel_idx + 1'b1;
  end

  // State register plus all registered datapath and outputs, falling-edge clocked
  always_ff @(negedge Clk_In or negedge Resetb_In) begin
    if (!Resetb_In) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      dur_q   <= '0;
      gray_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: abort or withdrawal beats pause, pause beats completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) state_d = RUN;
      end
      RUN: begin
        if (Abort_In || !owner_req)   state_d = IDLE;
        else if (!Pause_In && at_term) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output values for the coming edge, all taken from next state
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dur_d   = dur_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        grant_d = '0;
        if (req_any) begin
          grant_d[sel_idx] = 1'b1;
          dur_d            = dur_arr[sel_idx];
          ptr_d            = sel_next;
        end
      end
      RUN: begin
        if (state_d == IDLE) begin
          cnt_d   = '0;
          grant_d = '0;
        end else if (state_d == RUN && !Pause_In) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        grant_d = '0;
      end
      default: begin
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
    done_d = (state_d == DONE) ? grant_d : '0;
    busy_d = (state_d != IDLE);
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  assign Grant_Out      = grant_q;
  assign Done_Out       = done_q;
  assign Busy_Out       = busy_q;
  assign Gray_Count_Out = gray_q;

endmodule
